cache_arbiter: RTL

- Sits directly downstream of the CPU's L1 instruction and data caches. Takes their line-miss traffic (icache fill, dcache fill/writeback) and presents it to the unified L2 as one wishbone-style master port.
- Arbitrates one 128-bit line transaction at a time, with round-robin priority when both L1s request in the same cycle.
- Exports a saturating conflict counter to the performance-counter logic.

---
 rtl/cache_arbiter_pkg.sv | 14 +
 rtl/cache_arbiter_sat_counter.sv | 14 +
 rtl/cache_arbiter.sv | 92 +++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// cache_arbiter_pkg: line types, arbiter states and default widths shared by the L1/L2 arbiter.
package cache_arbiter_pkg;
   localparam int LINE_ADDR_W = 12;
   localparam int LINE_DATA_W = 128;
   localparam int LINE_SEL_W  = LINE_DATA_W / 8;
   localparam int CONF_CNT_W  = 16;

   typedef logic [LINE_DATA_W-1:0] lc3b_line;
   typedef logic [LINE_ADDR_W-1:0] lc3b_line_addr;
   typedef logic [LINE_SEL_W-1:0]  lc3b_line_sel;

   typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DRAIN} arb_state_t;
   typedef enum logic {PORT_I, PORT_D} arb_port_t;
endpackage

// File: rtl/cache_arbiter_sat_counter.sv
// sat_counter: up-counter that sticks at all ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) count <= '0;
      else        count <= clear ? '0 : (inc && !(&count)) ? count + W'(1) : count;
endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin merge of icache/dcache line misses onto one wishbone-style L2 master.
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int ADDR_W = LINE_ADDR_W,
   parameter int DATA_W = LINE_DATA_W,
   parameter int SEL_W  = LINE_SEL_W,
   parameter int CNT_W  = CONF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_stb,
   input  logic [ADDR_W-1:0] i_adr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_dat_s,
   input  logic              d_stb,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_adr,
   input  logic [DATA_W-1:0] d_dat_m,
   input  logic [SEL_W-1:0]  d_sel,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_dat_s,
   output logic              l2_stb,
   output logic              l2_cyc,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_adr,
   output logic [DATA_W-1:0] l2_dat_m,
   output logic [SEL_W-1:0]  l2_sel,
   input  logic              l2_ack,
   input  logic [DATA_W-1:0] l2_dat_s,
   output logic [CNT_W-1:0]  conflict_cnt
);
   arb_state_t state, state_nx;
   arb_port_t  last_grant;
   logic       grant, pick_d;

   // dcache wins alone, or on a tie when icache was served last
   assign pick_d = d_stb && (!i_stb || last_grant == PORT_I);

   always_comb begin
      state_nx = state;
      grant    = 1'b0;
      case (state)
         IDLE: begin
            grant    = i_stb || d_stb;
            state_nx = !grant ? IDLE : pick_d ? GRANT_D : GRANT_I;
         end
         GRANT_I: state_nx = l2_ack ? IDLE : i_stb ? GRANT_I : DRAIN;
         GRANT_D: state_nx = l2_ack ? IDLE : d_stb ? GRANT_D : DRAIN;
         DRAIN:   state_nx = l2_ack ? IDLE : DRAIN;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= PORT_I;
         l2_stb     <= 1'b0;
         l2_we      <= 1'b0;
         l2_adr     <= '0;
         l2_dat_m   <= '0;
         l2_sel     <= '0;
      end else begin
         state <= state_nx;
         if (grant) begin
            last_grant <= pick_d ? PORT_D : PORT_I;
            l2_stb     <= 1'b1;
            l2_we      <= pick_d && d_we;
            l2_adr     <= pick_d ? d_adr : i_adr;
            l2_dat_m   <= pick_d ? d_dat_m : '0;
            l2_sel     <= pick_d ? d_sel : '1;
         end else if (state_nx == IDLE) begin
            l2_stb <= 1'b0;
         end
      end

   assign l2_cyc  = l2_stb;
   assign i_ack   = state == GRANT_I && l2_ack && i_stb;
   assign d_ack   = state == GRANT_D && l2_ack && d_stb;
   assign i_dat_s = l2_dat_s;
   assign d_dat_s = l2_dat_s;

   // only one line moves at a time, so any cycle with both strobes up is a conflict
   sat_counter #(.W(CNT_W)) u_conflict (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (1'b0),
      .inc   (i_stb && d_stb),
      .count (conflict_cnt)
   );
endmodule
